// File: rtl/real_step_accum.sv
// real_step_accum: turns real STEP/INIT parameters into fixed point at elaboration and
// emits a valid/ready ramp of N_STEPS accumulated, wrapping samples per start request.
module real_step_accum #(
    parameter real STEP    = 2.0,
    parameter real INIT    = 0.0,
    parameter int  INT_W   = 8,
    parameter int  FRAC_W  = 8,
    parameter int  N_STEPS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT_W+FRAC_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);
    localparam int W = INT_W + FRAC_W;

    // Round to nearest with halves away from zero; $rtoi truncates toward zero.
    function automatic logic [W-1:0] to_fx(input real v);
        real s;
        s = v * (2.0 ** FRAC_W);
        return (s < 0.0) ? W'(-$rtoi(0.5 - s)) : W'($rtoi(s + 0.5));
    endfunction

    localparam logic [W-1:0] STEP_FX  = to_fx(STEP);
    localparam logic [W-1:0] INIT_FX  = to_fx(INIT);
    localparam logic [15:0]  LAST_CNT = 16'(N_STEPS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] acc_q, acc_d, add_a, sum;
    logic         ovf_q, ovf_d, add_ovf;
    logic [15:0]  cnt_q, cnt_d;

    assign add_a   = (state_q == IDLE) ? INIT_FX : acc_q;
    assign sum     = add_a + STEP_FX;
    assign add_ovf = (add_a[W-1] == STEP_FX[W-1]) && (sum[W-1] != add_a[W-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                acc_d   = sum;
                ovf_d   = add_ovf;
                cnt_d   = 16'd1;
            end
            RUN: if (out_ready) begin
                if (cnt_q == LAST_CNT) state_d = DONE;
                else begin
                    acc_d = sum;
                    ovf_d = add_ovf;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign out_data  = acc_q;
    assign out_ovf   = out_valid && ovf_q;
    assign out_last  = out_valid && (cnt_q == LAST_CNT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_real_step_accum.sv
// tb_real_step_accum: vector table for the default instance, scoreboard for
// instances with other real parameters, plus reset and generate-loop cases.
module tb_real_step_accum;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start_aux = 1'b0, ready = 1'b0;
    logic [15:0] data [10];
    logic [9:0]  valid, ovf, last, busy, done;
    int          n_checks = 0, n_fail = 0;

    typedef struct { int inst; logic [15:0] d; logic o; logic l; } exp_t;
    typedef struct { logic st; logic rdy; logic v; logic [15:0] d; logic l; logic b; logic dn; } vec_t;

    exp_t sb[$];
    vec_t tv [21];

    always #5 clk = ~clk;

    real_step_accum u0 (.clk(clk), .reset(reset), .start(start), .out_valid(valid[0]), .out_ready(ready), .out_data(data[0]), .out_ovf(ovf[0]), .out_last(last[0]), .busy(busy[0]), .done(done[0]));
    real_step_accum #(.STEP(10.5), .INIT(-1.5), .N_STEPS(2)) u1 (.clk(clk), .reset(reset), .start(start_aux), .out_valid(valid[1]), .out_ready(ready), .out_data(data[1]), .out_ovf(ovf[1]), .out_last(last[1]), .busy(busy[1]), .done(done[1]));
    real_step_accum #(.STEP(0.001953125), .N_STEPS(1)) u2 (.clk(clk), .reset(reset), .start(start_aux), .out_valid(valid[2]), .out_ready(ready), .out_data(data[2]), .out_ovf(ovf[2]), .out_last(last[2]), .busy(busy[2]), .done(done[2]));
    real_step_accum #(.STEP(-0.001953125), .N_STEPS(1)) u3 (.clk(clk), .reset(reset), .start(start_aux), .out_valid(valid[3]), .out_ready(ready), .out_data(data[3]), .out_ovf(ovf[3]), .out_last(last[3]), .busy(busy[3]), .done(done[3]));
    real_step_accum #(.STEP(0.0019), .N_STEPS(3)) u4 (.clk(clk), .reset(reset), .start(start_aux), .out_valid(valid[4]), .out_ready(ready), .out_data(data[4]), .out_ovf(ovf[4]), .out_last(last[4]), .busy(busy[4]), .done(done[4]));
    real_step_accum #(.STEP(100.0), .N_STEPS(3)) u5 (.clk(clk), .reset(reset), .start(start_aux), .out_valid(valid[5]), .out_ready(ready), .out_data(data[5]), .out_ovf(ovf[5]), .out_last(last[5]), .busy(busy[5]), .done(done[5]));

    for (genvar m = 0; m < 2; m++) begin : g_m
        for (genvar r = 0; r < 2; r++) begin : g_r
            real_step_accum #(.STEP((m + 1) * 10.0 + r + 0.5), .N_STEPS(1)) u (.clk(clk), .reset(reset), .start(start_aux), .out_valid(valid[6+2*m+r]), .out_ready(ready), .out_data(data[6+2*m+r]), .out_ovf(ovf[6+2*m+r]), .out_last(last[6+2*m+r]), .busy(busy[6+2*m+r]), .done(done[6+2*m+r]));
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [15:0] d, input logic o, input logic l);
        exp_t e;
        e.inst = i;
        e.d    = d;
        e.o    = o;
        e.l    = l;
        sb.push_back(e);
    endtask

    task automatic push_aux();
        push(1, 16'h0900, 1'b0, 1'b0);
        push(1, 16'h1380, 1'b0, 1'b1);
        push(2, 16'h0001, 1'b0, 1'b1);
        push(3, 16'hFFFF, 1'b0, 1'b1);
        push(4, 16'h0000, 1'b0, 1'b0);
        push(4, 16'h0000, 1'b0, 1'b0);
        push(4, 16'h0000, 1'b0, 1'b1);
        push(5, 16'h6400, 1'b0, 1'b0);
        push(5, 16'hC800, 1'b1, 1'b0);
        push(5, 16'h2C00, 1'b0, 1'b1);
        push(6, 16'h0A80, 1'b0, 1'b1);
        push(7, 16'h0B80, 1'b0, 1'b1);
        push(8, 16'h1480, 1'b0, 1'b1);
        push(9, 16'h1580, 1'b0, 1'b1);
    endtask

    function automatic vec_t mk(logic st, logic rdy, logic v, logic [15:0] d, logic l, logic b, logic dn);
        vec_t t;
        t.st = st; t.rdy = rdy; t.v = v; t.d = d; t.l = l; t.b = b; t.dn = dn;
        return t;
    endfunction

    // Each accepted aux sample must match the oldest pending expectation for that instance.
    always @(negedge clk) begin : mon
        int k;
        for (int i = 1; i < 10; i++) begin
            if (!reset && valid[i] && ready) begin
                k = -1;
                foreach (sb[j]) if (k < 0 && sb[j].inst == i) k = j;
                if (k < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL aux%0d unexpected sample: got %h, expected none", i, data[i]);
                end else begin
                    chk($sformatf("aux%0d data", i), data[i], sb[k].d);
                    chk($sformatf("aux%0d ovf", i), {15'd0, ovf[i]}, {15'd0, sb[k].o});
                    chk($sformatf("aux%0d last", i), {15'd0, last[i]}, {15'd0, sb[k].l});
                    sb.delete(k);
                end
            end
        end
    end

    initial begin
        tv[0]  = mk(1, 1, 1, 16'h0200, 0, 1, 0);
        tv[1]  = mk(0, 1, 1, 16'h0400, 0, 1, 0);
        tv[2]  = mk(0, 1, 1, 16'h0600, 0, 1, 0);
        tv[3]  = mk(0, 1, 1, 16'h0800, 1, 1, 0);
        tv[4]  = mk(0, 1, 0, 16'h0000, 0, 1, 1);
        tv[5]  = mk(0, 1, 0, 16'h0000, 0, 0, 0);
        tv[6]  = mk(1, 0, 1, 16'h0200, 0, 1, 0);
        tv[7]  = mk(0, 1, 1, 16'h0400, 0, 1, 0);
        tv[8]  = mk(0, 0, 1, 16'h0400, 0, 1, 0);
        tv[9]  = mk(1, 0, 1, 16'h0400, 0, 1, 0);
        tv[10] = mk(0, 0, 1, 16'h0400, 0, 1, 0);
        tv[11] = mk(0, 1, 1, 16'h0600, 0, 1, 0);
        tv[12] = mk(0, 1, 1, 16'h0800, 1, 1, 0);
        tv[13] = mk(0, 1, 0, 16'h0000, 0, 1, 1);
        tv[14] = mk(1, 0, 0, 16'h0000, 0, 0, 0);
        tv[15] = mk(1, 1, 1, 16'h0200, 0, 1, 0);
        tv[16] = mk(0, 1, 1, 16'h0400, 0, 1, 0);
        tv[17] = mk(0, 1, 1, 16'h0600, 0, 1, 0);
        tv[18] = mk(0, 1, 1, 16'h0800, 1, 1, 0);
        tv[19] = mk(0, 1, 0, 16'h0000, 0, 1, 1);
        tv[20] = mk(0, 0, 0, 16'h0000, 0, 0, 0);

        #2;
        chk("reset valid", {6'd0, valid}, 16'h0000);
        chk("reset busy", {6'd0, busy}, 16'h0000);
        chk("reset done", {6'd0, done}, 16'h0000);
        chk("reset last/ovf", {6'd0, last | ovf}, 16'h0000);
        chk("reset data", data[0], 16'h0000);
        @(posedge clk); #3;
        reset = 1'b0;

        for (int k = 0; k < 21; k++) begin
            start = tv[k].st;
            ready = tv[k].rdy;
            @(posedge clk); #3;
            chk($sformatf("vec%0d valid", k), {15'd0, valid[0]}, {15'd0, tv[k].v});
            chk($sformatf("vec%0d busy", k), {15'd0, busy[0]}, {15'd0, tv[k].b});
            chk($sformatf("vec%0d done", k), {15'd0, done[0]}, {15'd0, tv[k].dn});
            if (tv[k].v) begin
                chk($sformatf("vec%0d data", k), data[0], tv[k].d);
                chk($sformatf("vec%0d last", k), {15'd0, last[0]}, {15'd0, tv[k].l});
                chk($sformatf("vec%0d ovf", k), {15'd0, ovf[0]}, 16'h0000);
            end
        end

        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        chk("midrst s1", data[0], 16'h0200);
        @(posedge clk); #3;
        chk("midrst s2", data[0], 16'h0400);
        #1 reset = 1'b1;
        #1;
        chk("midrst valid", {15'd0, valid[0]}, 16'h0000);
        chk("midrst busy", {15'd0, busy[0]}, 16'h0000);
        chk("midrst done", {15'd0, done[0]}, 16'h0000);
        @(posedge clk); #3;
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        chk("restart valid", {15'd0, valid[0]}, 16'h0001);
        chk("restart data", data[0], 16'h0200);
        for (int c = 0; c < 10 && busy[0]; c++) begin
            @(posedge clk); #3;
        end
        chk("restart finished", {15'd0, busy[0]}, 16'h0000);

        push_aux();
        start_aux = 1'b1;
        ready = 1'b1;
        @(posedge clk); #3;
        start_aux = 1'b0;
        for (int c = 0; c < 30 && |busy[9:1]; c++) begin
            @(posedge clk); #3;
        end
        chk("aux run1 idle", {7'd0, busy[9:1]}, 16'h0000);
        chk("aux run1 drained", 16'(sb.size()), 16'h0000);

        push_aux();
        start_aux = 1'b1;
        @(posedge clk); #3;
        start_aux = 1'b0;
        for (int c = 0; c < 80 && |busy[9:1]; c++) begin
            ready = 1'($urandom_range(0, 1));
            @(posedge clk); #3;
        end
        chk("aux run2 idle", {7'd0, busy[9:1]}, 16'h0000);
        chk("aux run2 drained", 16'(sb.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
